// File: rtl/pcint_ctrl_if.sv
// CPU-side register bus shared by the I/O space and the data space.
interface pcint_ctrl_if;
  logic [5:0] IO_Addr;
  logic       iore;
  logic       iowe;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;

  modport master (
    output IO_Addr, iore, iowe, ramadr, ramre, ramwe, dbus_in,
    input  dbus_out, out_en
  );

  modport slave (
    input  IO_Addr, iore, iowe, ramadr, ramre, ramwe, dbus_in,
    output dbus_out, out_en
  );
endinterface

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt controller for groups B, C, D and E.
// Owns PCICR, PCIFR and PCMSK0-3; one sticky flag and irq per group.
module pcint_ctrl #(
  parameter logic [5:0] PCIFR_IO_ADDR = 6'h1B,
  parameter logic [7:0] PCICR_ADDR    = 8'h68,
  parameter logic [7:0] PCMSK0_ADDR   = 8'h6B,
  parameter logic [7:0] PCMSK3_ADDR   = 8'h73
) (
  input  logic              cp2,
  input  logic              ireset,
  pcint_ctrl_if.slave       bus,
  input  logic [7:0]        pinB_i,
  input  logic [6:0]        pinC_i,
  input  logic [7:0]        pinD_i,
  input  logic [3:0]        pinE_i,
  output logic [27:0]       PCINT,
  output logic [3:0]        PCIE,
  output logic [3:0]        pcint_irq,
  input  logic [3:0]        pcint_ack
);

  localparam logic [7:0] PCMSK1_ADDR = PCMSK0_ADDR + 8'd1;
  localparam logic [7:0] PCMSK2_ADDR = PCMSK0_ADDR + 8'd2;

  logic [3:0] pcicr_q, pcicr_d;
  logic [3:0] pcifr_q, pcifr_d;
  logic [7:0] msk0_q, msk0_d;
  logic [6:0] msk1_q, msk1_d;
  logic [7:0] msk2_q, msk2_d;
  logic [3:0] msk3_q, msk3_d;
  logic [7:0] prev_b_q;
  logic [6:0] prev_c_q;
  logic [7:0] prev_d_q;
  logic [3:0] prev_e_q;

  logic       sel_pcifr;
  logic [3:0] change;
  logic [3:0] flag_clr;

  assign sel_pcifr = (bus.IO_Addr == PCIFR_IO_ADDR);

  // Masks are the registered values, so a mask written this edge only
  // qualifies pin changes seen from the following edge onward.
  assign change[0] = |((pinB_i ^ prev_b_q) & msk0_q);
  assign change[1] = |((pinC_i ^ prev_c_q) & msk1_q);
  assign change[2] = |((pinD_i ^ prev_d_q) & msk2_q);
  assign change[3] = |((pinE_i ^ prev_e_q) & msk3_q);

  assign flag_clr = pcint_ack | ((bus.iowe && sel_pcifr) ? bus.dbus_in[3:0] : 4'h0);

  // Register writes and flag update; a new change wins over a same-cycle clear.
  always_comb begin
    pcicr_d = pcicr_q;
    msk0_d  = msk0_q;
    msk1_d  = msk1_q;
    msk2_d  = msk2_q;
    msk3_d  = msk3_q;
    if (bus.ramwe) begin
      case (bus.ramadr)
        PCICR_ADDR:  pcicr_d = bus.dbus_in[3:0];
        PCMSK0_ADDR: msk0_d  = bus.dbus_in;
        PCMSK1_ADDR: msk1_d  = bus.dbus_in[6:0];
        PCMSK2_ADDR: msk2_d  = bus.dbus_in;
        PCMSK3_ADDR: msk3_d  = bus.dbus_in[3:0];
        default: ;
      endcase
    end
    pcifr_d = change | (pcifr_q & ~flag_clr);
  end

  // State registers; prev pins reload every cycle unconditionally.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      pcicr_q  <= '0;
      pcifr_q  <= '0;
      msk0_q   <= '0;
      msk1_q   <= '0;
      msk2_q   <= '0;
      msk3_q   <= '0;
      prev_b_q <= '0;
      prev_c_q <= '0;
      prev_d_q <= '0;
      prev_e_q <= '0;
    end else begin
      pcicr_q  <= pcicr_d;
      pcifr_q  <= pcifr_d;
      msk0_q   <= msk0_d;
      msk1_q   <= msk1_d;
      msk2_q   <= msk2_d;
      msk3_q   <= msk3_d;
      prev_b_q <= pinB_i;
      prev_c_q <= pinC_i;
      prev_d_q <= pinD_i;
      prev_e_q <= pinE_i;
    end
  end

  // Combinational read mux; the I/O bus has priority over the data bus.
  always_comb begin
    bus.dbus_out = 8'h00;
    bus.out_en   = 1'b0;
    if (bus.iore && sel_pcifr) begin
      bus.out_en   = 1'b1;
      bus.dbus_out = {4'h0, pcifr_q};
    end else if (bus.ramre) begin
      case (bus.ramadr)
        PCICR_ADDR:  begin bus.out_en = 1'b1; bus.dbus_out = {4'h0, pcicr_q}; end
        PCMSK0_ADDR: begin bus.out_en = 1'b1; bus.dbus_out = msk0_q;          end
        PCMSK1_ADDR: begin bus.out_en = 1'b1; bus.dbus_out = {1'b0, msk1_q};  end
        PCMSK2_ADDR: begin bus.out_en = 1'b1; bus.dbus_out = msk2_q;          end
        PCMSK3_ADDR: begin bus.out_en = 1'b1; bus.dbus_out = {4'h0, msk3_q};  end
        default: ;
      endcase
    end
  end

  assign PCINT     = {msk3_q, msk2_q, 1'b0, msk1_q, msk0_q};
  assign PCIE      = pcicr_q;
  assign pcint_irq = pcifr_q & pcicr_q;

endmodule

// File: doc/pcint_ctrl.md
Name: pcint_ctrl

Overview:
- Pin-change interrupt controller for all four pin-change groups: PCINT[7:0] on port B, [14:8] on C, [23:16] on D, [27:24] on E.
- Consumes the synchronized pin values that the port blocks produce on DIE_o.
- Owns the PCICR, PCIFR and PCMSK0–3 registers.
- Drives the PCINT mask and PCIEn enables back into the port blocks, where they override digital-input-enable.
- Raises one interrupt request per group to the interrupt vector unit and clears on acknowledge.

Parameters:
- PCIFR_IO_ADDR, 6'h1B, I/O address of PCIFR.
- PCICR_ADDR, 8'h68, data-space address of PCICR.
- PCMSK0_ADDR, 8'h6B, data-space address of PCMSK0; PCMSK1 = +1, PCMSK2 = +2.
- PCMSK3_ADDR, 8'h73, data-space address of PCMSK3.

Ports:
- cp2  in  1  system clock; all state updates on rising edge.
- ireset  in  1  asynchronous active-low reset.
- IO_Addr  in  6  I/O-space address.
- iore  in  1  I/O read strobe.
- iowe  in  1  I/O write strobe.
- ramadr  in  8  data-space address low byte; upper byte = 0 is decoded upstream.
- ramre  in  1  data-space read strobe.
- ramwe  in  1  data-space write strobe.
- dbus_in  in  8  write data.
- dbus_out  out  8  read data; 0 when not selected.
- out_en  out  1  high while an owned register is being read on either bus.
- pinB_i  in  8  synchronized port B pin values.
- pinC_i  in  7  synchronized port C pin values.
- pinD_i  in  8  synchronized port D pin values.
- pinE_i  in  4  synchronized port E pin values.
- PCINT  out  28  mask bits {PCMSK3[3:0], PCMSK2, 1'b0, PCMSK1[6:0], PCMSK0}; bit 15 is always 0.
- PCIE  out  4  PCICR[3:0]; PCIE[3] feeds port E.
- pcint_irq  out  4  interrupt request per group.
- pcint_ack  in  4  one-cycle vector-taken acknowledge per group.

Behaviour:
- Reset (ireset = 0, async):
  - PCICR, PCIFR and all PCMSK registers clear to 0.
  - prev-pin registers clear to 0.
  - All outputs go to 0.
- Register map:
  - PCICR[3:0] is R/W; bits [7:4] read 0 and ignore writes.
  - PCMSK0, PCMSK2 are 8-bit R/W.
  - PCMSK1[6:0] is R/W; bit 7 reads 0.
  - PCMSK3[3:0] is R/W; upper bits read 0.
  - PCIFR[3:0] reads the flags; writing 1 clears that flag, writing 0 has no effect; bits [7:4] read 0.
- Register writes take effect at the rising edge where iowe/ramwe is sampled high with a matching address.
- Reads are combinational: out_en and dbus_out are valid in the same cycle as iore/ramre with a matching address.
- Edge detection:
  - A prev register per pin loads the current pin value every cycle, unconditionally.
  - change_g = |((pins_g ^ prev_g) & PCMSKg), evaluated against the registered mask.
  - A mask written at edge N only qualifies detections from edge N+1 onward.
- Flag set: when change_g = 1 at edge N, PCIFg = 1 after edge N.
  - The flag is set regardless of PCIEg.
  - Latency is one cycle from a pin value differing from prev to the flag becoming visible.
- pcint_irq[g] = PCIFg & PCIEg, combinational from registers, so it has no extra cycle of latency.
- Flag clear: pcint_ack[g] or a PCIFR write-1 clears PCIFg at the edge.
- Simultaneous set and clear in the same cycle: set wins, so the new event is not lost.
- Multiple masked pins changing in one cycle produce a single flag set.
- Flags are sticky; they are not re-set while already 1.
- Toggle within a cycle: the pin is sampled each edge; a glitch shorter than one cycle that the upstream synchronizer misses produces no flag.
- Clearing PCIEg while PCIFg = 1:
  - irq drops next cycle and the flag remains set.
  - Re-enabling asserts irq again.
- Reset asserted mid-operation: all flags and masks clear immediately (async), and irq deasserts without waiting for a clock.
- After reset release, prev = 0 while masks = 0, so no spurious flag can occur.
- Both buses addressing owned registers in the same cycle cannot occur (CPU issues one access); the I/O bus takes mux priority.

Test Plan:
- Reset, then read PCICR, PCIFR, PCMSK0–3 -> all read 0x00; PCINT = 0, PCIE = 0, pcint_irq = 0.
- Write PCMSK3 = 0x05, PCICR = 0x08; toggle pinE_i[0] 0->1 -> PCIFR reads 0x08 one edge later and pcint_irq = 4'b1000; toggle pinE_i[1] with its mask bit 0 -> no flag.
- With PCIF3 set, pulse pcint_ack[3] -> flag and irq clear next edge; repeat with pinE_i[2] toggling in the ack cycle -> flag stays 1.
- Write PCIFR = 0x01 while PCIF0 = 1 and PCIF1 = 1 -> PCIFR reads 0x02; write 0x00 -> unchanged.
- PCMSK0 = 0xFF, PCIE = 0; toggle pinB_i -> PCIFR = 0x01, irq = 0; then write PCICR = 0x01 -> pcint_irq[0] = 1.
- Assert ireset mid-flag with PCIF2 set -> pcint_irq[2] drops before the next cp2 edge; read PCMSK1 bit 7 after writing 0xFF -> reads 0x7F.
